// File: rtl/ex_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one bit per clock, stalls the pipeline while busy.
// Optional build macro MULDIV_EARLY_OUT_EN: zero-operand ops skip RUN and complete in the cycle after accept.
module ex_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     raw_a_q, raw_a_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_lo_q, neg_lo_d;
    logic                 neg_hi_q, neg_hi_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 div_zero_q, div_zero_d;

    logic                 sgn;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum, div_t, div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quot, rem, res_hi, res_lo;
    logic                 commit;

    always_comb begin
        sgn      = ~op[0];
        mag_a    = (sgn && opa[WIDTH-1]) ? -opa : opa;
        mag_b    = (sgn && opb[WIDTH-1]) ? -opb : opb;
        // acc holds {partial product high, multiplier} or {remainder, dividend/quotient}
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? m_q : '0)};
        div_t    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_t - {1'b0, m_q};
        div_ge   = (div_t >= {1'b0, m_q});

        prod = neg_lo_q ? -acc_q : acc_q;
        quot = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (!is_div_q) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (dz_q) begin
            res_hi = raw_a_q;
            res_lo = '1;
        end else begin
            res_hi = rem;
            res_lo = quot;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        m_d        = m_q;
        raw_a_d    = raw_a_q;
        is_div_d   = is_div_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    is_div_d = op[1];
                    cnt_d    = '0;
                    acc_d    = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                    m_d      = op[1] ? mag_b : mag_a;
                    raw_a_d  = opa;
                    dz_d     = op[1] && (opb == '0);
                    neg_lo_d = sgn && (opa[WIDTH-1] ^ opb[WIDTH-1]);
                    neg_hi_d = sgn && opa[WIDTH-1];
                    state_d  = RUN;
`ifdef MULDIV_EARLY_OUT_EN
                    if (opa == '0 || opb == '0) begin
                        acc_d   = '0;
                        state_d = DONE;
                    end
`else
`endif
                end else if (!start) begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q)
                        acc_d = {(div_ge ? div_diff[WIDTH-1:0] : div_t[WIDTH-1:0]),
                                 acc_q[WIDTH-2:0], div_ge};
                    else
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!flush) begin
                    hi_d = res_hi;
                    lo_d = res_lo;
                    if (is_div_q) div_zero_d = dz_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            m_q        <= '0;
            raw_a_q    <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            m_q        <= m_d;
            raw_a_q    <= raw_a_d;
            is_div_q   <= is_div_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Result is visible in DONE but only committed on exit, so a DONE-cycle flush leaves HI/LO untouched
    assign commit   = (state_q == DONE) && !flush;
    assign busy     = (state_q != IDLE);
    assign stall    = ((state_q == IDLE) && start) || (state_q == RUN);
    assign done     = commit;
    assign hi       = commit ? res_hi : hi_q;
    assign lo       = commit ? res_lo : lo_q;
    assign div_zero = (commit && is_div_q) ? dz_q : div_zero_q;
endmodule
